// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: handshaked multi-cycle command sequencer driving the ALU and a 32-bit accumulator
// Ports:
//   clk, rst_n (sync, active-low)
//   cmd_valid/cmd_ready, cmd_op[3:0], cmd_operand[15:0] : command accept
//   alu_a[15:0], alu_b[15:0], alu_op[3:0]              : to ALU (alu_b = acc[15:0])
//   alu_result[31:0], alu_overflow                     : from ALU
//   acc[31:0]                                          : accumulator
//   rsp_valid, rsp_err[1:0]                            : one-cycle retire pulse, {div0, add/sub overflow}
//   busy                                               : high outside IDLE
// Build option: ALU_SEQ_DIVZERO_HOLD_EN keeps acc unchanged on divide-by-zero.
module alu_op_sequencer #(
   parameter int MUL_LAT  = 4,
   parameter int DIV_LAT  = 8,
   parameter int BASE_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_op,
   input  logic [15:0] cmd_operand,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [3:0]  alu_op,
   input  logic [31:0] alu_result,
   input  logic        alu_overflow,
   output logic [31:0] acc,
   output logic        rsp_valid,
   output logic [1:0]  rsp_err,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   localparam logic [3:0] OP_NOP = 4'hD;
   state_t      state, state_nx;
   logic [7:0]  cnt, lat_in;
   logic [3:0]  op_q;
   logic [15:0] opnd_q;
   logic        accept, div_in, divz_in, divz, ovf, wr;
   logic [31:0] acc_nx;
   // Divide-by-zero is decided from acc at accept time; acc cannot change during EXEC.
   assign accept  = cmd_valid && cmd_ready;
   assign div_in  = cmd_op == 4'd1 || cmd_op == 4'd2;
   assign divz_in = div_in && acc[15:0] == 16'd0;
   assign lat_in  = cmd_op == 4'd4 ? 8'(MUL_LAT) : (div_in && !divz_in) ? 8'(DIV_LAT) : 8'(BASE_LAT);
   assign divz    = (op_q == 4'd1 || op_q == 4'd2) && acc[15:0] == 16'd0;
   assign ovf     = (op_q == 4'd0 || op_q == 4'd8) && alu_overflow;
   assign wr      = state == EXEC && cnt == 8'd0;
`ifdef ALU_SEQ_DIVZERO_HOLD_EN
   assign acc_nx  = (op_q == OP_NOP || divz) ? acc : alu_result;
`else
   assign acc_nx  = op_q == OP_NOP ? acc : alu_result;
`endif
   always_comb begin
      state_nx  = state == IDLE ? (accept ? EXEC : IDLE) : state == EXEC ? (cnt == 8'd0 ? RESP : EXEC) : IDLE;
      cmd_ready = state == IDLE;
      busy      = state != IDLE;
      rsp_valid = state == RESP;
      alu_op    = state == EXEC ? op_q : OP_NOP;
      alu_a     = state == EXEC ? opnd_q : 16'd0;
      alu_b     = acc[15:0];
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         acc     <= 32'd0;
         rsp_err <= 2'b00;
         cnt     <= 8'd0;
         op_q    <= OP_NOP;
         opnd_q  <= 16'd0;
      end else begin
         state <= state_nx;
         if (accept) begin
            op_q   <= cmd_op;
            opnd_q <= cmd_operand;
            cnt    <= lat_in - 8'd1;
         end else if (state == EXEC && cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
         end
         if (wr) begin
            acc     <= acc_nx;
            rsp_err <= {divz, ovf};
         end
      end
   end
endmodule
